// File: rtl/hls_deadlock_report_ctrl_if.sv
// Signal bundle between the deadlock report controller and the rest of the
// dataflow region.
//   enable          : arms detection (region -> controller)
//   dl_detect_vec   : per-process dl_detect_out of every detect unit
//   report_ack      : one-cycle release of a held report
//   origin_vec      : one-hot origin strobe to the selected unit
//   token_clear     : one-cycle pulse killing the circulating token
//   dl_detect_bcast : dl_detect_in broadcast to every unit
//   dl_found        : confirmed deadlock, held until acknowledged
//   dl_proc_id      : origin process of the confirmed deadlock
//   dl_proc_vec     : processes that asserted detect during circulation
//   dl_timeout      : one-cycle pulse, circulation aborted as false alarm
// modport master is the controller side, slave the region/software side.
interface hls_deadlock_report_ctrl_if #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2
);
    logic                enable;
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic                report_ack;
    logic [PROC_NUM-1:0] origin_vec;
    logic                token_clear;
    logic                dl_detect_bcast;
    logic                dl_found;
    logic [ID_W-1:0]     dl_proc_id;
    logic [PROC_NUM-1:0] dl_proc_vec;
    logic                dl_timeout;

    modport master (
        input  enable, dl_detect_vec, report_ack,
        output origin_vec, token_clear, dl_detect_bcast,
               dl_found, dl_proc_id, dl_proc_vec, dl_timeout
    );

    modport slave (
        output enable, dl_detect_vec, report_ack,
        input  origin_vec, token_clear, dl_detect_bcast,
               dl_found, dl_proc_id, dl_proc_vec, dl_timeout
    );
endinterface

// File: rtl/hls_deadlock_report_ctrl.sv
// Central deadlock report controller for an HLS dataflow region.
// Picks one requesting detect unit round-robin as origin, broadcasts the
// detection mode, waits a bounded time for the token to come back to the
// origin, then either latches a report (held until report_ack) or aborts
// with a timeout pulse.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : controller side of hls_deadlock_report_ctrl_if (see that file)
// Every output is a flop fed from next-state logic, so no input reaches an
// output combinationally.
module hls_deadlock_report_ctrl #(
    parameter int PROC_NUM   = 4,
    parameter int MAX_CYCLES = 64,
    parameter int ID_W       = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    hls_deadlock_report_ctrl_if.master bus
);
    localparam int unsigned      PN       = PROC_NUM;
    localparam int               CNT_W    = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(PROC_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        ORIGIN,
        CIRCULATE,
        REPORT
    } state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]     sel, sel_n;
    logic [ID_W-1:0]     sel_inc;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ID_W-1:0]     pick;
    logic                pick_valid;
    logic [31:0]         scan_idx;

    logic [PROC_NUM-1:0] origin_vec_q, origin_vec_n;
    logic                token_clear_q, token_clear_n;
    logic                bcast_q, bcast_n;
    logic                found_q, found_n;
    logic [ID_W-1:0]     proc_id_q, proc_id_n;
    logic [PROC_NUM-1:0] proc_vec_q, proc_vec_n;
    logic                timeout_q, timeout_n;

    // Round-robin scan starting at rr_ptr; first requester found wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < PN; i++) begin
            scan_idx = (32'(rr_ptr) + i) % PN;
            if (!pick_valid && bus.dl_detect_vec[scan_idx[ID_W-1:0]]) begin
                pick       = scan_idx[ID_W-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    assign sel_inc = (sel == ID_LAST) ? '0 : sel + 1'b1;

    always_comb begin
        state_n       = state;
        sel_n         = sel;
        rr_ptr_n      = rr_ptr;
        cnt_n         = cnt;
        proc_vec_n    = proc_vec_q;
        proc_id_n     = proc_id_q;
        token_clear_n = 1'b0;
        timeout_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.enable && pick_valid) begin
                    sel_n      = pick;
                    proc_vec_n = '0;
                    cnt_n      = '0;
                    state_n    = ORIGIN;
                end
            end
            ORIGIN: begin
                // cnt reads 0 during ORIGIN, so the first CIRCULATE cycle
                // sees 1 and the timeout lands MAX_CYCLES cycles after ORIGIN.
                cnt_n   = CNT_W'(1);
                state_n = CIRCULATE;
            end
            CIRCULATE: begin
                proc_vec_n = proc_vec_q | bus.dl_detect_vec;
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + 1'b1;
                end
                // Confirm is tested first so it wins over a coincident timeout.
                if (bus.dl_detect_vec[sel] && (cnt != '0)) begin
                    token_clear_n = 1'b1;
                    proc_id_n     = sel;
                    state_n       = REPORT;
                end else if (cnt == CNT_LAST) begin
                    token_clear_n = 1'b1;
                    timeout_n     = 1'b1;
                    rr_ptr_n      = sel_inc;
                    state_n       = IDLE;
                end
            end
            REPORT: begin
                if (bus.report_ack) begin
                    rr_ptr_n = sel_inc;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Level outputs are derived from the next state so they are
        // registered alongside it.
        origin_vec_n = '0;
        if (state_n == ORIGIN) begin
            origin_vec_n[sel_n] = 1'b1;
        end
        bcast_n = (state_n != IDLE);
        found_n = (state_n == REPORT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr        <= '0;
            sel           <= '0;
            cnt           <= '0;
            origin_vec_q  <= '0;
            token_clear_q <= 1'b0;
            bcast_q       <= 1'b0;
            found_q       <= 1'b0;
            proc_id_q     <= '0;
            proc_vec_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            rr_ptr        <= rr_ptr_n;
            sel           <= sel_n;
            cnt           <= cnt_n;
            origin_vec_q  <= origin_vec_n;
            token_clear_q <= token_clear_n;
            bcast_q       <= bcast_n;
            found_q       <= found_n;
            proc_id_q     <= proc_id_n;
            proc_vec_q    <= proc_vec_n;
            timeout_q     <= timeout_n;
        end
    end

    assign bus.origin_vec      = origin_vec_q;
    assign bus.token_clear     = token_clear_q;
    assign bus.dl_detect_bcast = bcast_q;
    assign bus.dl_found        = found_q;
    assign bus.dl_proc_id      = proc_id_q;
    assign bus.dl_proc_vec     = proc_vec_q;
    assign bus.dl_timeout      = timeout_q;
endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
module tb_hls_deadlock_report_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    hls_deadlock_report_ctrl_if #(.PROC_NUM(4), .ID_W(2)) bus ();

    hls_deadlock_report_ctrl #(
        .PROC_NUM  (4),
        .MAX_CYCLES(8),
        .ID_W      (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.enable        = 1'b0;
        bus.dl_detect_vec = 4'b0000;
        bus.report_ack    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_origin",  32'(bus.origin_vec),      32'h0);
        chk("rst_tclr",    32'(bus.token_clear),     32'h0);
        chk("rst_bcast",   32'(bus.dl_detect_bcast), 32'h0);
        chk("rst_found",   32'(bus.dl_found),        32'h0);
        chk("rst_id",      32'(bus.dl_proc_id),      32'h0);
        chk("rst_pvec",    32'(bus.dl_proc_vec),     32'h0);
        chk("rst_timeout", 32'(bus.dl_timeout),      32'h0);
        chk("rst_rr",      32'(dut.rr_ptr),          32'h0);
        reset = 1'b0;
        tick();

        // Single requester: process 2
        bus.enable        = 1'b1;
        bus.dl_detect_vec = 4'b0100;
        tick();
        chk("t1_origin", 32'(bus.origin_vec),      32'h4);
        chk("t1_bcast",  32'(bus.dl_detect_bcast), 32'h1);
        bus.dl_detect_vec = 4'b0000;
        tick();
        chk("t1_origin_drop", 32'(bus.origin_vec), 32'h0);
        tick();
        bus.dl_detect_vec = 4'b0100;
        tick();
        chk("t1_tclr",    32'(bus.token_clear), 32'h1);
        chk("t1_found",   32'(bus.dl_found),    32'h1);
        chk("t1_id",      32'(bus.dl_proc_id),  32'h2);
        chk("t1_pvec",    32'(bus.dl_proc_vec), 32'h4);
        chk("t1_timeout", 32'(bus.dl_timeout),  32'h0);
        bus.dl_detect_vec = 4'b0000;
        tick();
        chk("t1_tclr_once",  32'(bus.token_clear),     32'h0);
        chk("t1_found_hold", 32'(bus.dl_found),        32'h1);
        chk("t1_bcast_hold", 32'(bus.dl_detect_bcast), 32'h1);
        bus.report_ack = 1'b1;
        tick();
        bus.report_ack = 1'b0;
        chk("t1_found_ack", 32'(bus.dl_found),        32'h0);
        chk("t1_bcast_ack", 32'(bus.dl_detect_bcast), 32'h0);
        chk("t1_pvec_keep", 32'(bus.dl_proc_vec),     32'h4);
        chk("t1_rr",        32'(dut.rr_ptr),          32'h3);

        // Round robin: rr_ptr=3, requests 0101 -> process 0 first
        bus.dl_detect_vec = 4'b0101;
        tick();
        chk("t2_origin0", 32'(bus.origin_vec), 32'h1);
        bus.dl_detect_vec = 4'b0000;
        tick();
        bus.dl_detect_vec = 4'b0001;
        tick();
        chk("t2_found0", 32'(bus.dl_found),   32'h1);
        chk("t2_id0",    32'(bus.dl_proc_id), 32'h0);
        bus.dl_detect_vec = 4'b0000;
        bus.report_ack    = 1'b1;
        tick();
        bus.report_ack = 1'b0;
        chk("t2_rr1", 32'(dut.rr_ptr), 32'h1);
        bus.dl_detect_vec = 4'b0101;
        tick();
        chk("t2_origin2", 32'(bus.origin_vec), 32'h4);
        bus.dl_detect_vec = 4'b0000;
        tick();
        bus.dl_detect_vec = 4'b0100;
        tick();
        chk("t2_id2", 32'(bus.dl_proc_id), 32'h2);
        bus.dl_detect_vec = 4'b0000;
        bus.report_ack    = 1'b1;
        tick();
        bus.report_ack = 1'b0;

        // Timeout: rr_ptr=3, origin 1 never returns
        bus.dl_detect_vec = 4'b0010;
        tick();
        chk("t3_origin1", 32'(bus.origin_vec), 32'h2);
        bus.dl_detect_vec = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_no_early_pulse", 32'({bus.token_clear, bus.dl_timeout}), 32'h0);
        end
        tick();
        chk("t3_tclr",    32'(bus.token_clear),     32'h1);
        chk("t3_timeout", 32'(bus.dl_timeout),      32'h1);
        chk("t3_found",   32'(bus.dl_found),        32'h0);
        chk("t3_bcast",   32'(bus.dl_detect_bcast), 32'h0);
        tick();
        chk("t3_pulses_end", 32'({bus.token_clear, bus.dl_timeout}), 32'h0);
        chk("t3_rr",         32'(dut.rr_ptr),                        32'h2);

        // Participants and confirm-vs-timeout tie: rr_ptr=2, origin 0
        bus.dl_detect_vec = 4'b0001;
        tick();
        chk("t4_origin0", 32'(bus.origin_vec), 32'h1);
        bus.dl_detect_vec = 4'b0000;
        tick();
        bus.dl_detect_vec = 4'b0010;
        tick();
        bus.dl_detect_vec = 4'b1000;
        tick();
        bus.dl_detect_vec = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        bus.dl_detect_vec = 4'b0001;
        tick();
        chk("t4_found",   32'(bus.dl_found),    32'h1);
        chk("t4_timeout", 32'(bus.dl_timeout),  32'h0);
        chk("t4_tclr",    32'(bus.token_clear), 32'h1);
        chk("t4_pvec",    32'(bus.dl_proc_vec), 32'hB);
        chk("t4_id",      32'(bus.dl_proc_id),  32'h0);
        bus.dl_detect_vec = 4'b0000;
        bus.report_ack    = 1'b1;
        tick();
        bus.report_ack = 1'b0;

        // Gating: enable low, then a stray ack in IDLE
        bus.enable        = 1'b0;
        bus.dl_detect_vec = 4'b1111;
        tick();
        tick();
        tick();
        chk("t5_origin", 32'(bus.origin_vec),      32'h0);
        chk("t5_bcast",  32'(bus.dl_detect_bcast), 32'h0);
        chk("t5_rr",     32'(dut.rr_ptr),          32'h1);
        bus.report_ack = 1'b1;
        tick();
        bus.report_ack = 1'b0;
        chk("t5_ack_found", 32'(bus.dl_found),    32'h0);
        chk("t5_ack_pvec",  32'(bus.dl_proc_vec), 32'hB);
        chk("t5_ack_rr",    32'(dut.rr_ptr),      32'h1);
        bus.enable = 1'b1;
        tick();
        chk("t5_origin1", 32'(bus.origin_vec), 32'h2);

        // Reset in the middle of a circulation
        bus.dl_detect_vec = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_origin", 32'(bus.origin_vec),      32'h0);
        chk("t6_bcast",  32'(bus.dl_detect_bcast), 32'h0);
        chk("t6_tclr",   32'(bus.token_clear),     32'h0);
        chk("t6_found",  32'(bus.dl_found),        32'h0);
        chk("t6_pvec",   32'(bus.dl_proc_vec),     32'h0);
        chk("t6_rr",     32'(dut.rr_ptr),          32'h0);
        bus.dl_detect_vec = 4'b1001;
        tick();
        chk("t6_origin_after", 32'(bus.origin_vec), 32'h1);
        bus.dl_detect_vec = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
